// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data, optional parity and 1/2 stop bits,
// each lasting a programmable number of clock cycles; drives serializer and line mux.
module uart_tx_ctrl #(
    parameter int DATA_W = 8,
    parameter int PS_W   = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Data_Valid,
    input  logic            PAR_EN,
    input  logic            Stop2,
    input  logic [PS_W-1:0] Prescale,
    output logic            Busy,
    output logic            Ser_Load,
    output logic            Ser_Shift,
    output logic [1:0]      Mux_Sel,
    output logic            Frame_Done
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_DATA  = 2'b01;
    localparam logic [1:0] MUX_PAR   = 2'b10;
    localparam logic [1:0] MUX_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PS_W-1:0] r_pcnt;
    logic [PS_W-1:0] w_pcnt_nxt;
    logic [PS_W-1:0] r_prescale;
    logic [PS_W-1:0] w_prescale_nxt;
    logic [BC_W-1:0] r_bcnt;
    logic [BC_W-1:0] w_bcnt_nxt;
    logic            r_stop_cnt;
    logic            w_stop_cnt_nxt;
    logic            r_par_en;
    logic            w_par_en_nxt;
    logic            r_stop2;
    logic            w_stop2_nxt;

    logic            r_busy;
    logic            r_ser_shift;
    logic            r_frame_done;
    logic [1:0]      r_mux_sel;
    logic            w_busy_nxt;
    logic            w_shift_nxt;
    logic            w_done_nxt;
    logic [1:0]      w_mux_nxt;

    logic            w_accept;
    logic            w_period_end;
    logic [PS_W-1:0] w_ps_eff;

    assign w_accept     = Data_Valid && (r_state == S_IDLE);
    assign w_ps_eff     = (Prescale == '0) ? PS_W'(1) : Prescale;
    assign w_period_end = (r_pcnt == (r_prescale - PS_W'(1)));

    // Next-state and counter update; configuration is only sampled on accept.
    always_comb begin
        w_state_nxt    = r_state;
        w_pcnt_nxt     = r_pcnt;
        w_bcnt_nxt     = r_bcnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_prescale_nxt = r_prescale;
        w_par_en_nxt   = r_par_en;
        w_stop2_nxt    = r_stop2;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_START;
                    w_pcnt_nxt     = '0;
                    w_prescale_nxt = w_ps_eff;
                    w_par_en_nxt   = PAR_EN;
                    w_stop2_nxt    = Stop2;
                end
            end
            S_START: begin
                if (w_period_end) begin
                    w_state_nxt = S_DATA;
                    w_pcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt + PS_W'(1);
                end
            end
            S_DATA: begin
                if (w_period_end) begin
                    w_pcnt_nxt = '0;
                    if (r_bcnt == BC_W'(DATA_W - 1)) begin
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bcnt_nxt = r_bcnt + BC_W'(1);
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt + PS_W'(1);
                end
            end
            S_PARITY: begin
                if (w_period_end) begin
                    w_state_nxt    = S_STOP;
                    w_pcnt_nxt     = '0;
                    w_stop_cnt_nxt = 1'b0;
                end else begin
                    w_pcnt_nxt = r_pcnt + PS_W'(1);
                end
            end
            S_STOP: begin
                if (w_period_end) begin
                    w_pcnt_nxt = '0;
                    if (r_stop2 && !r_stop_cnt) begin
                        w_stop_cnt_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt + PS_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pcnt_nxt  = '0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they move with it.
    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_shift_nxt = (w_state_nxt == S_DATA) &&
                      (w_pcnt_nxt == (w_prescale_nxt - PS_W'(1)));
        w_done_nxt  = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
        case (w_state_nxt)
            S_START:  w_mux_nxt = MUX_START;
            S_DATA:   w_mux_nxt = MUX_DATA;
            S_PARITY: w_mux_nxt = MUX_PAR;
            default:  w_mux_nxt = MUX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_pcnt       <= '0;
            r_bcnt       <= '0;
            r_stop_cnt   <= 1'b0;
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_stop2      <= 1'b0;
            r_busy       <= 1'b0;
            r_mux_sel    <= MUX_IDLE;
            r_ser_shift  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_stop_cnt   <= w_stop_cnt_nxt;
            r_prescale   <= w_prescale_nxt;
            r_par_en     <= w_par_en_nxt;
            r_stop2      <= w_stop2_nxt;
            r_busy       <= w_busy_nxt;
            r_mux_sel    <= w_mux_nxt;
            r_ser_shift  <= w_shift_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    assign Ser_Load   = w_accept;
    assign Busy       = r_busy;
    assign Mux_Sel    = r_mux_sel;
    assign Ser_Shift  = r_ser_shift;
    assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-level model predicts every output cycle by cycle,
// and directed frames pin lengths, shift positions and mux sequences to literals.
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int PSW = 6;

    logic           CLK = 1'b0;
    logic           RST;
    logic           Data_Valid;
    logic           PAR_EN;
    logic           Stop2;
    logic [PSW-1:0] Prescale;
    logic           Busy;
    logic           Ser_Load;
    logic           Ser_Shift;
    logic [1:0]     Mux_Sel;
    logic           Frame_Done;

    uart_tx_ctrl #(.DATA_W(DW), .PS_W(PSW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .Stop2      (Stop2),
        .Prescale   (Prescale),
        .Busy       (Busy),
        .Ser_Load   (Ser_Load),
        .Ser_Shift  (Ser_Shift),
        .Mux_Sel    (Mux_Sel),
        .Frame_Done (Frame_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       busy;
        logic [1:0] mux;
        logic       shift;
        logic       done;
    } exp_t;

    localparam exp_t IDLE_E = 5'b0_11_0_0;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int frames = 0, load_cnt = 0, done_cnt = 0;
    int cur_len = 0, last_len = 0, cur_shift = 0, first_shift = 0, last_shift = 0;
    int mux11 = 0, idle_len = 0;
    bit prev_busy = 1'b0, done_at_fall = 1'b0;
    logic [1:0] mux_log [0:127];
    int frame_len [0:15];
    int frame_gap [0:15];

    // Expected output stream for one frame: each bit lasts p cycles, shift on the
    // last cycle of every data bit, then one idle cycle carrying Frame_Done.
    function automatic void push_frame(int p, bit pe, bit s2);
        int         nb;
        logic [1:0] m;
        exp_t       e;
        nb = 2 + DW + int'(pe) + int'(s2);
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                m = 2'b00;
            else if (b <= DW)          m = 2'b01;
            else if (pe && b == DW + 1) m = 2'b10;
            else                       m = 2'b11;
            for (int c = 0; c < p; c++) begin
                e.busy  = 1'b1;
                e.mux   = m;
                e.shift = (m == 2'b01) && (c == p - 1);
                e.done  = 1'b0;
                exp_q.push_back(e);
            end
        end
        e      = IDLE_E;
        e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(int p, bit pe, bit s2);
        tick();
        Prescale   = PSW'(p);
        PAR_EN     = pe;
        Stop2      = s2;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    task automatic wait_frames(int target);
        int k;
        k = 0;
        while (frames < target && k < 3000) begin
            tick();
            k++;
        end
        check("frame_complete", 32'(frames >= target), 1);
    endtask

    initial begin
        int base, lbase, dbase, k;
        logic [1:0] em;
        RST        = 1'b1;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        Stop2      = 1'b0;
        Prescale   = PSW'(1);

        fork
            begin : model
                exp_t cur;
                forever begin
                    @(posedge CLK or posedge RST);
                    if (RST) begin
                        exp_q.delete();
                    end else begin
                        cur = (exp_q.size() > 0) ? exp_q[0] : IDLE_E;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        if (Data_Valid && !cur.busy)
                            push_frame((Prescale == 0) ? 1 : int'(Prescale), PAR_EN, Stop2);
                    end
                end
            end
            begin : compare
                exp_t e;
                forever begin
                    @(negedge CLK);
                    if (RST) begin
                        prev_busy = 1'b0;
                        cur_len   = 0;
                    end else begin
                        e = (exp_q.size() > 0) ? exp_q[0] : IDLE_E;
                        check("busy", Busy, e.busy);
                        check("mux_sel", Mux_Sel, e.mux);
                        check("ser_shift", Ser_Shift, e.shift);
                        check("frame_done", Frame_Done, e.done);
                        check("ser_load", Ser_Load, Data_Valid && !e.busy);
                        if (Ser_Load)   load_cnt++;
                        if (Frame_Done) done_cnt++;
                        if (Busy) begin
                            if (!prev_busy) begin
                                frame_gap[frames % 16] = idle_len;
                                cur_len = 0; cur_shift = 0; first_shift = 0;
                                last_shift = 0; mux11 = 0;
                            end
                            cur_len++;
                            if (cur_len <= 128) mux_log[cur_len-1] = Mux_Sel;
                            if (Ser_Shift) begin
                                cur_shift++;
                                if (first_shift == 0) first_shift = cur_len;
                                last_shift = cur_len;
                            end
                            if (Mux_Sel == 2'b11) mux11++;
                            idle_len = 0;
                        end else begin
                            if (prev_busy) begin
                                last_len = cur_len;
                                frame_len[frames % 16] = cur_len;
                                done_at_fall = Frame_Done;
                                frames++;
                            end
                            idle_len++;
                        end
                        prev_busy = Busy;
                    end
                end
            end
        join_none

        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_mux", Mux_Sel, 2'b11);
        check("rst_shift", Ser_Shift, 0);
        check("rst_done", Frame_Done, 0);
        RST = 1'b0;
        repeat (2) tick();

        // P=1, parity, one stop bit
        base = frames; lbase = load_cnt;
        send(1, 1'b1, 1'b0);
        wait_frames(base + 1);
        check("p1_len", last_len, 11);
        check("p1_loads", load_cnt - lbase, 1);
        check("p1_shifts", cur_shift, 8);
        check("p1_first_shift", first_shift, 2);
        check("p1_last_shift", last_shift, 9);
        check("p1_done_at_fall", done_at_fall, 1);
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      em = 2'b00;
            else if (i <= 8) em = 2'b01;
            else if (i == 9) em = 2'b10;
            else             em = 2'b11;
            check("p1_mux_seq", mux_log[i], em);
        end

        // P=4, no parity, two stop bits
        base = frames;
        send(4, 1'b0, 1'b1);
        wait_frames(base + 1);
        check("p4_len", last_len, 44);
        check("p4_shifts", cur_shift, 8);
        check("p4_first_shift", first_shift, 8);
        check("p4_last_shift", last_shift, 36);
        check("p4_stop_cycles", mux11, 8);

        // Reset in the middle of the data bits
        dbase = done_cnt;
        send(4, 1'b0, 1'b0);
        repeat (10) tick();
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("midrst_busy", Busy, 0);
        check("midrst_mux", Mux_Sel, 2'b11);
        tick();
        tick();
        RST = 1'b0;
        repeat (3) tick();
        check("midrst_no_done", done_cnt - dbase, 0);
        base = frames;
        send(4, 1'b0, 1'b0);
        wait_frames(base + 1);
        check("after_rst_len", last_len, 40);

        // Data_Valid held for three back-to-back frames
        base = frames; lbase = load_cnt;
        tick();
        Prescale = PSW'(2); PAR_EN = 1'b1; Stop2 = 1'b0; Data_Valid = 1'b1;
        k = 0;
        while (load_cnt < lbase + 3 && k < 500) begin
            tick();
            k++;
        end
        Data_Valid = 1'b0;
        wait_frames(base + 3);
        repeat (4) tick();
        check("b2b_loads", load_cnt - lbase, 3);
        for (int i = 0; i < 3; i++) check("b2b_len", frame_len[(base + i) % 16], 22);
        for (int i = 1; i < 3; i++) check("b2b_gap", frame_gap[(base + i) % 16], 1);

        // Configuration change during a frame
        base = frames;
        send(2, 1'b1, 1'b0);
        repeat (5) tick();
        PAR_EN = 1'b0; Stop2 = 1'b1; Prescale = PSW'(5);
        wait_frames(base + 1);
        check("cfg_old_len", last_len, 22);
        check("cfg_old_parity", mux_log[18], 2'b10);
        check("cfg_old_stop", mux11, 2);
        base = frames;
        send(5, 1'b0, 1'b1);
        wait_frames(base + 1);
        check("cfg_new_len", last_len, 55);
        check("cfg_new_stop", mux11, 10);

        // Prescale 0 behaves as 1
        base = frames;
        send(0, 1'b0, 1'b0);
        wait_frames(base + 1);
        check("p0_len", last_len, 10);
        check("p0_shifts", cur_shift, 8);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
